// File: rtl/apb4_mem_slave.sv
// APB4 completer in front of a word-addressed RAM with byte strobes, wait states,
// PSLVERR on misaligned/out-of-range addresses, abort handling and an error counter.
module apb4_mem_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [7:0]              err_count
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned LSB = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IW  = ADDR_WIDTH - LSB;
  localparam int unsigned MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = 4;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  // Elaboration-time parameter sanity
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("apb4_mem_slave: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (DEPTH > (1 << IW)) begin : g_bad_depth
    $error("apb4_mem_slave: DEPTH exceeds addressable words");
  end
  if (WAIT_STATES > 15) begin : g_bad_ws
    $error("apb4_mem_slave: WAIT_STATES must be 0..15");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0] word_idx;
  logic [MW-1:0] mem_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          addr_err;

  assign word_idx     = PADDR[ADDR_WIDTH-1:LSB];
  assign mem_idx      = MW'(word_idx);
  assign out_of_range = {1'b0, word_idx} >= (IW+1)'(DEPTH);
  assign addr_err     = misaligned | out_of_range;

  if (LSB == 0) begin : g_no_align
    assign misaligned = 1'b0;
  end else begin : g_align
    assign misaligned = |PADDR[LSB-1:0];
  end

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic [7:0]            err_count_d;
  logic                  mem_we;

  // Next-state and next-output decode; PREADY/PSLVERR are computed one cycle ahead
  // so that the ports come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    prdata_d    = PRDATA;
    err_count_d = err_count;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = S_ACCESS;
          err_d    = addr_err;
          cnt_d    = CW'(WAIT_STATES);
          prdata_d = (!PWRITE && !addr_err) ? mem[mem_idx] : '0;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (PENABLE) begin
          state_d = S_IDLE;
          if (err_q) begin
            if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
          end else if (PWRITE) begin
            mem_we = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    pready_d  = (state_d == S_ACCESS) && (cnt_d == '0);
    pslverr_d = pready_d && err_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      PREADY    <= pready_d;
      PSLVERR   <= pslverr_d;
      PRDATA    <= prdata_d;
      err_count <= err_count_d;
    end
  end

  // Byte-lane write on the completing edge; storage is intentionally not reset
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (PSTRB[i]) mem[mem_idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Randomized APB4 bench: two instances (0 and 3 wait states) checked against a
// word-array reference model with byte merging, error rules and a saturating counter.
module tb_apb4_mem_slave;

  localparam int DEPTH = 256;
  localparam int WS_A  = 0;
  localparam int WS_B  = 3;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [11:0] paddr;
  logic        psel_a, psel_b, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [31:0] prdata_a, prdata_b;
  logic        ready_a, ready_b, slverr_a, slverr_b;
  logic [7:0]  errcnt_a, errcnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [2][DEPTH];
  int          ref_errcnt [2];
  logic [31:0] last_rd [2];

  always #5 PCLK = ~PCLK;

  apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel_a), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_a),
    .PREADY(ready_a), .PSLVERR(slverr_a), .err_count(errcnt_a)
  );

  apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel_b), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_b),
    .PREADY(ready_b), .PSLVERR(slverr_b), .err_count(errcnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? WS_A : WS_B;
  endfunction
  function automatic logic dut_ready(input int d);
    return (d == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic dut_slverr(input int d);
    return (d == 0) ? slverr_a : slverr_b;
  endfunction
  function automatic logic [31:0] dut_rdata(input int d);
    return (d == 0) ? prdata_a : prdata_b;
  endfunction
  function automatic logic [7:0] dut_errcnt(input int d);
    return (d == 0) ? errcnt_a : errcnt_b;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // One APB transfer on instance d; abort_at>0 drops PSEL in that cycle of the transfer
  task automatic apb_xfer(input int d, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int abort_at);
    int          cyc;
    int          idx;
    logic        err_exp;
    logic        timed_out;
    logic [31:0] old;
    idx     = int'(addr[11:2]);
    err_exp = (addr[1:0] != 2'b00) || (idx >= DEPTH);
    old     = err_exp ? 32'h0 : ref_mem[d][idx];
    @(negedge PCLK);
    psel_a = (d == 0); psel_b = (d == 1); penable = 1'b0;
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    check_eq("setup_ready", 32'(dut_ready(d)), 32'h0);
    check_eq("err_count", 32'(dut_errcnt(d)), 32'(ref_errcnt[d]));
    last_rd[d] = (wr || err_exp) ? 32'h0 : old;
    @(negedge PCLK);
    penable = 1'b1;
    cyc = 2;
    timed_out = 1'b0;
    while (cyc != abort_at && !dut_ready(d) && !timed_out) begin
      if (cyc >= 40) timed_out = 1'b1;
      else begin
        @(negedge PCLK);
        cyc++;
      end
    end
    if (timed_out) begin
      check_eq("ready_timeout", 32'(cyc), 32'(ws(d) + 2));
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    end else if (cyc == abort_at) begin
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
      @(negedge PCLK);
      check_eq("abort_ready", 32'(dut_ready(d)), 32'h0);
    end else begin
      check_eq("latency", 32'(cyc), 32'(ws(d) + 2));
      check_eq("pslverr", 32'(dut_slverr(d)), 32'(err_exp));
      if (!wr) check_eq("prdata", dut_rdata(d), old);
      if (err_exp) begin
        if (ref_errcnt[d] < 255) ref_errcnt[d]++;
      end else if (wr) begin
        ref_mem[d][idx] = merge(old, wdata, strb);
      end
    end
  endtask

  // Park the bus and confirm PRDATA holds on both instances
  task automatic bus_idle();
    @(negedge PCLK);
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check_eq("hold_a", prdata_a, last_rd[0]);
    check_eq("hold_b", prdata_b, last_rd[1]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] addr;
    int          d, k, ab;
    PRESETn = 1'b0;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    ref_errcnt[0] = 0; ref_errcnt[1] = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) @(negedge PCLK);
    check_eq("rst_ready_a", 32'(ready_a), 32'h0);
    check_eq("rst_slverr_a", 32'(slverr_a), 32'h0);
    check_eq("rst_rdata_a", prdata_a, 32'h0);
    check_eq("rst_errcnt_a", 32'(errcnt_a), 32'h0);
    check_eq("rst_ready_b", 32'(ready_b), 32'h0);
    check_eq("rst_rdata_b", prdata_b, 32'h0);
    check_eq("rst_errcnt_b", 32'(errcnt_b), 32'h0);
    PRESETn = 1'b1;

    // Give every word a known value in both instances
    for (int i = 0; i < DEPTH; i++) begin
      apb_xfer(0, 1'b1, 12'(i * 4), $urandom, 4'hF, 0);
      apb_xfer(1, 1'b1, 12'(i * 4), $urandom, 4'hF, 0);
    end

    // Zero-wait write then back-to-back read of the same word
    apb_xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0);
    apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 0);
    bus_idle();
    check_eq("t1_rdata", prdata_a, 32'hDEADBEEF);

    // Partial byte strobes
    apb_xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, 0);
    apb_xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 0);
    apb_xfer(0, 1'b0, 12'h020, 32'h0, 4'hF, 0);
    bus_idle();
    check_eq("t2_rdata", prdata_a, 32'h11BB33DD);

    // Out-of-range write, misaligned read, word 0 untouched, then saturation
    apb_xfer(0, 1'b1, 12'h400, 32'hCAFEF00D, 4'hF, 0);
    apb_xfer(0, 1'b0, 12'h402, 32'h0, 4'h0, 0);
    apb_xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, 0);
    bus_idle();
    check_eq("t4_errcnt_two", 32'(errcnt_a), 32'd2);
    for (int i = 0; i < 300; i++) apb_xfer(0, 1'b0, 12'hFFC, 32'h0, 4'h0, 0);
    bus_idle();
    check_eq("t4_errcnt_sat", 32'(errcnt_a), 32'd255);

    // Wait-state reads, back to back
    apb_xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, 0);
    apb_xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, 0);

    // Write with no strobes leaves memory alone
    apb_xfer(0, 1'b1, 12'h040, 32'h12345678, 4'h0, 0);
    apb_xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, 0);

    // Abort a waited write, then read the old value back
    apb_xfer(1, 1'b1, 12'h030, 32'h0BADC0DE, 4'hF, 3);
    apb_xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 0);
    bus_idle();

    // Random mix over both instances
    for (int n = 0; n < 300; n++) begin
      d = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 9));
      if (k == 0)      addr = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (k == 1) addr = 12'($urandom_range(256, 1023) * 4);
      else             addr = 12'($urandom_range(0, 15) * 4);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, ws(d) + 2)) : 0;
      apb_xfer(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), ab);
      if ($urandom_range(0, 3) == 0) bus_idle();
    end

    // Reset in the middle of a waited write
    apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 0);
    apb_xfer(1, 1'b0, 12'h401, 32'h0, 4'h0, 0);
    @(negedge PCLK);
    psel_a = 1'b0; psel_b = 1'b1; penable = 1'b0;
    paddr = 12'h030; pwrite = 1'b1; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check_eq("rst_mid_ready_b", 32'(ready_b), 32'h0);
    check_eq("rst_mid_rdata_b", prdata_b, 32'h0);
    check_eq("rst_mid_errcnt_b", 32'(errcnt_b), 32'h0);
    check_eq("rst_mid_rdata_a", prdata_a, 32'h0);
    check_eq("rst_mid_errcnt_a", 32'(errcnt_a), 32'h0);
    ref_errcnt[0] = 0; ref_errcnt[1] = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge PCLK);
    psel_b = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 0);
    apb_xfer(1, 1'b1, 12'h030, 32'h600DF00D, 4'hF, 0);
    apb_xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 0);
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
